// File: rtl/grf_hazard_scoreboard.sv
// GRF hazard scoreboard: Tuse/Tnew stall and forward-select for the D stage.
// Optional HAZARD_STATS_EN adds a saturating stall_cycles counter.
module grf_hazard_scoreboard (
    input  logic       clk,
    input  logic       reset,
    input  logic       d_valid,
    input  logic [4:0] d_rs,
    input  logic [1:0] d_rs_tuse,
    input  logic [4:0] d_rt,
    input  logic [1:0] d_rt_tuse,
    input  logic [4:0] d_a3,
    input  logic [1:0] d_tnew,
    output logic       stall,
    output logic [1:0] fwd_rs_sel,
    output logic [1:0] fwd_rt_sel,
    output logic [4:0] w_a3,
    output logic       w_we
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0] stall_cycles
`endif
);

    typedef struct packed {
        logic [4:0] a3;
        logic [1:0] tnew;
    } ent_t;

    typedef struct packed {
        logic       stall;
        logic [1:0] sel;
    } opchk_t;

    ent_t e_q, m_q, w_q;
    opchk_t rs_c, rt_c;

    function automatic logic [1:0] dec(input logic [1:0] x);
        return (x == 2'd0) ? 2'd0 : x - 2'd1;
    endfunction

    // Youngest-first match of one source operand against E, M, W.
    function automatic opchk_t check(
        input logic       v,
        input logic [4:0] r,
        input logic [1:0] tuse,
        input ent_t       e,
        input ent_t       m,
        input ent_t       w
    );
        opchk_t     c;
        logic       act;
        logic       hit;
        logic [1:0] t;
        logic [1:0] s;
        c   = '0;
        act = v && (r != 5'd0) && (tuse != 2'd3);
        hit = 1'b1;
        t   = 2'd0;
        s   = 2'd0;
        if (e.a3 == r) begin
            t = e.tnew;
            s = 2'd1;
        end else if (m.a3 == r) begin
            t = m.tnew;
            s = 2'd2;
        end else if (w.a3 == r) begin
            t = w.tnew;
            s = 2'd3;
        end else begin
            hit = 1'b0;
        end
        c.stall = act && hit && (t > tuse);
        c.sel   = (act && hit && (t == 2'd0)) ? s : 2'd0;
        return c;
    endfunction

    // Hazard evaluation for both operands and GRF write port.
    always_comb begin
        rs_c       = check(d_valid, d_rs, d_rs_tuse, e_q, m_q, w_q);
        rt_c       = check(d_valid, d_rt, d_rt_tuse, e_q, m_q, w_q);
        stall      = rs_c.stall | rt_c.stall;
        fwd_rs_sel = rs_c.sel;
        fwd_rt_sel = rt_c.sel;
        w_a3       = w_q.a3;
        w_we       = (w_q.a3 != 5'd0);
    end

    // Advance destinations down the pipe; bubble into E on stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            w_q <= '{a3: m_q.a3, tnew: dec(m_q.tnew)};
            m_q <= '{a3: e_q.a3, tnew: dec(e_q.tnew)};
            if (d_valid && !stall)
                e_q <= '{a3: d_a3, tnew: d_tnew};
            else
                e_q <= '0;
        end
    end

`ifdef HAZARD_STATS_EN
    // Saturating count of stalled cycles.
    always_ff @(posedge clk) begin
        if (reset)
            stall_cycles <= '0;
        else if (stall && (stall_cycles != 16'hFFFF))
            stall_cycles <= stall_cycles + 16'd1;
    end
`endif

endmodule

// File: doc/grf_hazard_scoreboard.md
# grf_hazard_scoreboard

- Tracks pending register-file writes across the E, M and W pipeline stages of the five-stage MIPS core.
- Each cycle it decides whether the D-stage instruction must stall, and which stage feeds each D-stage operand.
- Sits beside the GRF and drives its write address/enable from the W-stage entry.
- Uses the Tuse/Tnew model: every in-flight destination carries a countdown until its result is forwardable.

## Interface
- No parameters.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `d_valid` in 1: D stage holds a real instruction.
- `d_rs` in 5: D-stage source register 1.
- `d_rs_tuse` in 2: cycles until rs is consumed (0..2); 3 = not read.
- `d_rt` in 5: D-stage source register 2.
- `d_rt_tuse` in 2: same encoding as `d_rs_tuse`, for rt.
- `d_a3` in 5: D-stage destination; 0 = no write.
- `d_tnew` in 2: cycles, counted from E entry, until the result is held in a pipeline register (0..2).
- `stall` out 1: hold F/D, inject bubble into E.
- `fwd_rs_sel` out 2: 0 = GRF, 1 = E, 2 = M, 3 = W.
- `fwd_rt_sel` out 2: same encoding, for rt.
- `w_a3` out 5: GRF write address.
- `w_we` out 1: GRF write enable; equals (`w_a3` != 0).

## Operation
- **Stage state.** Three entries E, M, W, each holding {a3[4:0], tnew[1:0]}. The empty entry is {0,0}.
- **Per-clock update** (reset low):
  - W <= {M.a3, dec(M.tnew)}.
  - M <= {E.a3, dec(E.tnew)}.
  - E <= {d_a3, d_tnew} when `d_valid` & !`stall`; otherwise {0,0}.
  - dec(x) = (x == 0) ? 0 : x - 1, i.e. it saturates at 0.
- **Operand check**, evaluated independently for rs and rt:
  - The operand is active iff `d_valid`, the register is != 0, and tuse != 3.
  - Youngest match = first of E, M, W (in that order) whose a3 equals the register and a3 != 0.
  - Older matches are ignored.
- **Stall.** `stall` = OR over both operands of (active & match exists & match.tnew > tuse).
- **Forward select**:
  - Inactive operand, no match, or match.tnew != 0: sel = 0.
  - Otherwise sel = 1, 2 or 3 for a match in E, M or W respectively.
- Forward selects are driven even while `stall` = 1; the datapath ignores them during a stall.
- `w_a3` = W.a3.
- A bubble or $0 destination never matches and never writes.

## Timing
- `stall`, `fwd_*_sel`, `w_a3` and `w_we` are purely combinational from the current inputs and stage state; zero-cycle latency.
- Stage state changes only on posedge `clk`.
- **Reset:** synchronous, and takes priority over every other event, including mid-stall. It clears E, M and W to {0,0}, so the next cycle shows:
  - `stall` = 0;
  - `fwd_rs_sel` = `fwd_rt_sel` = 0;
  - `w_a3` = 0, `w_we` = 0.
- A stalled instruction re-evaluates every cycle against the advancing E/M/W state. Worst case is 2 consecutive stall cycles (tnew 2, tuse 0).
- A `d_valid` & `stall` cycle inserts exactly one bubble into E; the D-stage instruction itself is not lost.
- rs == rt: both operands evaluate identically, and `stall` counts that dependence once.

## Configuration
- `HAZARD_STATS_EN` defined:
  - Adds output `stall_cycles` out 16: counts cycles with `stall` = 1.
  - Saturates at 16'hFFFF.
  - Cleared by reset.
- `HAZARD_STATS_EN` undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- **Reset.** Assert `reset` one cycle with E/M/W populated → next cycle `stall` = 0, both sels = 0, `w_we` = 0, `w_a3` = 0.
- **Load-use, branch.** Issue a3=1, tnew=2, then D reads rs=1, tuse=0:
  - `stall` = 1 for 2 cycles.
  - Third cycle: `stall` = 0, `fwd_rs_sel` = 3.
- **Load-use, ALU.** Same load with reader rs=1, tuse=1 → `stall` = 1 for 1 cycle, then `stall` = 0 with `fwd_rs_sel` = 0.
- **ALU then branch.** a3=2, tnew=1, then rt=2, tuse=0 → 1 stall cycle, then `fwd_rt_sel` = 2.
- **Zero-tnew writers.**
  - jal: a3=31, tnew=0, followed by rs=31, tuse=0 → no stall, `fwd_rs_sel` = 1.
  - Two back-to-back writes to $3 (both tnew=0), then rs=3 → `fwd_rs_sel` = 1 (youngest wins).
- **$0 and stats.** a3=0, tnew=2, then rs=0, tuse=0 → no stall, sel = 0, `w_we` never 1. With `HAZARD_STATS_EN`, the load-use branch case leaves `stall_cycles` = 2.
